wb_stage: RTL and testbench

// - MEM/WB pipeline register plus write-back datapath; sits directly upstream of the register file.
// - Captures the retiring instruction from MEM and aligns/extends load data from data memory.
// - Selects the write-back source and drives the register-file write port (wb_en, wb_data, rd_index).
// - wb_data also serves as the WB-stage forwarding source for EX.

---
 rtl/wb_stage.sv | 102 ++++++++++
 tb/tb_wb_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with load alignment and write-back source select.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             hold WB contents / load a bubble (flush wins)
//   mem_*                    retiring instruction fields from MEM
//   dm_rdata                 raw data-memory word for the instruction in WB
//   wb_valid                 WB register holds a real instruction
//   wb_en, rd_index, wb_data register-file write port (wb_data also feeds EX forwarding)
//   instret_count            retired-instruction count
// Optional feature: define WB_INSTRET_EN to build the retire counter; otherwise instret_count is 0.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd_index,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    input  logic [XLEN-1:0]  dm_rdata,
    output logic             wb_valid,
    output logic             wb_en,
    output logic [4:0]       rd_index,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] instret_count
);
    logic            reg_write_q;
    logic [1:0]      sel_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_v;
    logic            retire;

    // Flush only clears the valid bit; the remaining fields are masked through wb_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            reg_write_q <= 1'b0;
            rd_index    <= '0;
            sel_q       <= '0;
            f3_q        <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= mem_valid;
            reg_write_q <= mem_reg_write;
            rd_index    <= mem_rd_index;
            sel_q       <= mem_wb_sel;
            f3_q        <= mem_funct3;
            alu_q       <= mem_alu_result;
            pc4_q       <= mem_pc_plus4;
            imm_q       <= mem_imm;
        end
    end

    // Halfword select uses only off[1]; off[0] is ignored for LH/LHU.
    always_comb begin
        shifted = dm_rdata >> {alu_q[1:0], 3'b000};
        byte_v  = shifted[7:0];
        half_v  = alu_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_v  = (f3_q == 3'b000) ? {{24{byte_v[7]}}, byte_v} :
                  (f3_q == 3'b100) ? {24'b0, byte_v} :
                  (f3_q == 3'b001) ? {{16{half_v[15]}}, half_v} :
                  (f3_q == 3'b101) ? {16'b0, half_v} : dm_rdata;
        wb_data = (sel_q == 2'b00) ? alu_q :
                  (sel_q == 2'b01) ? load_v :
                  (sel_q == 2'b10) ? pc4_q : imm_q;
    end

    assign retire = wb_valid & ~stall;
    assign wb_en  = retire & reg_write_q & (rd_index != 5'd0);

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_q + 1'b1;
    end

    assign instret_count = cnt_q;
`else
    assign instret_count = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;
`ifdef WB_INSTRET_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd_index;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_imm, dm_rdata;
    logic        wb_valid, wb_en;
    logic [4:0]  rd_index;
    logic [31:0] wb_data;
    logic [63:0] instret_count;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd_index(mem_rd_index), .mem_wb_sel(mem_wb_sel),
        .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_en(wb_en), .rd_index(rd_index),
        .wb_data(wb_data), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ec(input int n);
        return CNT_ON ? 64'(n) : 64'd0;
    endfunction

    task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd_index = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc4; mem_imm = imm;
        step();
        mem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd_index = 5'd7; mem_wb_sel = 2'b00;
        mem_funct3 = 3'b010; mem_alu_result = 32'h55; mem_pc_plus4 = 32'h4; mem_imm = 32'h9;
        dm_rdata = 32'h80FF7F01;
        step(); step();
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_en", 64'(wb_en), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_cnt", instret_count, 64'd0);
        rst = 1'b0; mem_valid = 1'b0;

        issue(5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0);
        chk("alu_en", 64'(wb_en), 64'd1);
        chk("alu_rd", 64'(rd_index), 64'd5);
        chk("alu_data", 64'(wb_data), 64'h1234);
        issue(5'd0, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0);
        chk("rd0_en", 64'(wb_en), 64'd0);
        chk("rd0_data", 64'(wb_data), 64'h1234);

        issue(5'd3, 2'b01, 3'b000, 32'h1001, 32'h0, 32'h0);
        chk("lb_off1", 64'(wb_data), 64'h0000007F);
        issue(5'd3, 2'b01, 3'b000, 32'h1003, 32'h0, 32'h0);
        chk("lb_off3", 64'(wb_data), 64'hFFFFFF80);
        issue(5'd3, 2'b01, 3'b100, 32'h1002, 32'h0, 32'h0);
        chk("lbu_off2", 64'(wb_data), 64'h000000FF);
        issue(5'd3, 2'b01, 3'b001, 32'h1002, 32'h0, 32'h0);
        chk("lh_off2", 64'(wb_data), 64'hFFFF80FF);
        issue(5'd3, 2'b01, 3'b001, 32'h1003, 32'h0, 32'h0);
        chk("lh_off3", 64'(wb_data), 64'hFFFF80FF);
        issue(5'd3, 2'b01, 3'b101, 32'h1000, 32'h0, 32'h0);
        chk("lhu_off0", 64'(wb_data), 64'h00007F01);
        issue(5'd3, 2'b01, 3'b010, 32'h1003, 32'h0, 32'h0);
        chk("lw", 64'(wb_data), 64'h80FF7F01);
        issue(5'd3, 2'b01, 3'b111, 32'h1002, 32'h0, 32'h0);
        chk("ld_other", 64'(wb_data), 64'h80FF7F01);
        step();
        chk("idle_valid", 64'(wb_valid), 64'd0);
        chk("idle_en", 64'(wb_en), 64'd0);
        chk("cnt_loads", instret_count, ec(10));

        issue(5'd1, 2'b10, 3'b000, 32'h0, 32'h100, 32'hABCD0000);
        chk("sel_pc4", 64'(wb_data), 64'h100);
        issue(5'd1, 2'b11, 3'b000, 32'h0, 32'h100, 32'hABCD0000);
        chk("sel_imm", 64'(wb_data), 64'hABCD0000);
        step();
        chk("cnt_sel", instret_count, ec(12));

        issue(5'd9, 2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h0);
        stall = 1'b1;
        mem_valid = 1'b1; mem_rd_index = 5'd4; mem_alu_result = 32'hBEEF;
        #1;
        chk("stall_en0", 64'(wb_en), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_en", 64'(wb_en), 64'd0);
            chk("stall_data", 64'(wb_data), 64'hDEAD);
            chk("stall_rd", 64'(rd_index), 64'd9);
            chk("stall_cnt", instret_count, ec(12));
        end
        stall = 1'b0; mem_valid = 1'b0;
        #1;
        chk("release_en", 64'(wb_en), 64'd1);
        chk("release_data", 64'(wb_data), 64'hDEAD);
        step();
        chk("release_once", 64'(wb_en), 64'd0);
        chk("release_cnt", instret_count, ec(13));

        issue(5'd6, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0);
        flush = 1'b1; stall = 1'b1;
        mem_valid = 1'b1; mem_rd_index = 5'd2; mem_alu_result = 32'h88;
        step();
        flush = 1'b0; stall = 1'b0; mem_valid = 1'b0;
        #1;
        chk("flush_valid", 64'(wb_valid), 64'd0);
        chk("flush_en", 64'(wb_en), 64'd0);
        chk("flush_cnt", instret_count, ec(13));
        step();
        chk("flush_cnt2", instret_count, ec(13));

        issue(5'd8, 2'b00, 3'b000, 32'h42, 32'h0, 32'h0);
        stall = 1'b1; rst = 1'b1;
        #1;
        chk("rst_stall_en", 64'(wb_en), 64'd0);
        step();
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("rst_stall_valid", 64'(wb_valid), 64'd0);
        chk("rst_stall_data", 64'(wb_data), 64'd0);
        chk("rst_stall_cnt", instret_count, 64'd0);

        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd_index = 5'd10;
        mem_wb_sel = 2'b00; mem_alu_result = 32'h1;
        repeat (10) step();
        mem_valid = 1'b0;
        step();
        chk("cnt_ten", instret_count, ec(10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
